// File: rtl/objects_mux_collision.sv
// Pixel mux for four prioritized screen objects over a background, registered to VGA,
// plus per-frame pairwise overlap detection reported as a snapshot at each startOfFrame.
module objects_mux_collision #(
    parameter logic [7:0] TRANSPARENT_ENCODING = 8'hFF,
    parameter logic [7:0] DEFAULT_BG_RGB       = 8'h00
) (
    input  logic            clk,
    input  logic            resetN,
    input  logic            startOfFrame,
    input  logic [3:0]      objDrawingRequest,
    input  logic [3:0][7:0] objRGB,
    input  logic            bgDrawingRequest,
    input  logic [7:0]      bgRGB,
    output logic [7:0]      RGBOut,
    output logic [2:0]      drawSource,
    output logic [5:0]      collisionPairs,
    output logic            collisionAny,
    output logic            collisionValid,
    output logic            state_dbg
);

    typedef enum logic {ACCUM = 1'b0, SNAP = 1'b1} state_t;

    state_t     state, state_next;
    logic [3:0] eff;
    logic [5:0] hits;
    logic [5:0] accum;
    logic [5:0] snapshot;
    logic [7:0] rgb_next;
    logic [2:0] src_next;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            eff[i] = objDrawingRequest[i] && (objRGB[i] != TRANSPARENT_ENCODING);
        end
    end

    // Bit order {2-3, 1-3, 1-2, 0-3, 0-2, 0-1}
    assign hits = {eff[2] & eff[3], eff[1] & eff[3], eff[1] & eff[2],
                   eff[0] & eff[3], eff[0] & eff[2], eff[0] & eff[1]};

    // Hits on the boundary cycle belong to the closing frame's snapshot
    assign snapshot = accum | hits;

    always_comb begin
        rgb_next = DEFAULT_BG_RGB;
        src_next = 3'd5;
        if (eff[0]) begin
            rgb_next = objRGB[0];
            src_next = 3'd0;
        end else if (eff[1]) begin
            rgb_next = objRGB[1];
            src_next = 3'd1;
        end else if (eff[2]) begin
            rgb_next = objRGB[2];
            src_next = 3'd2;
        end else if (eff[3]) begin
            rgb_next = objRGB[3];
            src_next = 3'd3;
        end else if (bgDrawingRequest) begin
            rgb_next = bgRGB;
            src_next = 3'd4;
        end
    end

    always_comb begin
        state_next     = ACCUM;
        collisionValid = 1'b0;
        case (state)
            ACCUM: begin
                if (startOfFrame) state_next = SNAP;
            end
            SNAP: begin
                collisionValid = 1'b1;
                if (startOfFrame) state_next = SNAP;
            end
            default: state_next = ACCUM;
        endcase
    end

    assign state_dbg = state;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state          <= ACCUM;
            RGBOut         <= DEFAULT_BG_RGB;
            drawSource     <= 3'd5;
            accum          <= 6'd0;
            collisionPairs <= 6'd0;
            collisionAny   <= 1'b0;
        end else begin
            state      <= state_next;
            RGBOut     <= rgb_next;
            drawSource <= src_next;
            if (startOfFrame) begin
                collisionPairs <= snapshot;
                collisionAny   <= |snapshot;
                accum          <= 6'd0;
            end else begin
                accum <= snapshot;
            end
        end
    end

endmodule
